hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the single-cycle load-use hazard detector in the MIPS32 pipeline.
//  Tracks a per-register countdown (scoreboard) of cycles until each pending result can be forwarded.
//  Also tracks busy time of a non-pipelined multiply unit (MDU), and stalls IF/ID while inserting EX bubbles.
//  Sits beside the ID stage; drives PC write enable, IF/ID write enable and ID/EX bubble-insert.
// PARAMETERS
//  REG_ADDR_W  5   register address width; NUM_REGS = 2**REG_ADDR_W
//  LOAD_LAT    1   cycles after issue before a load result is forwardable (1 = classic one bubble)
//  MUL_LAT     4   cycles after issue before a mul result is forwardable; also MDU busy time
//  CNT_W       $clog2(max(LOAD_LAT,MUL_LAT)+1)   derived, not overridden
//  PERF_W      32  width of stall performance counter
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           synchronous reset, active low
//  id_valid      in   1           ID holds a real instruction
//  id_flush      in   1           kill ID instruction this cycle (taken branch/jump)
//  id_rs_addr    in   REG_ADDR_W  first source register
//  id_rs_used    in   1           instruction reads rs
//  id_rt_addr    in   REG_ADDR_W  second source register
//  id_rt_used    in   1           instruction reads rt
//  id_wr_addr    in   REG_ADDR_W  destination register
//  id_wr_en      in   1           instruction writes a register
//  id_is_load    in   1           instruction is a load
//  id_is_mul     in   1           instruction uses the MDU
//  convert_to_nop out 1           insert bubble into ID/EX
//  if_id_write   out  1           IF/ID register write enable
//  pc_write      out  1           PC write enable
//  stall_cycles  out  PERF_W      saturating count of stalled cycles
// BEHAVIOUR
//  - State: sb_cnt[NUM_REGS] (CNT_W each), mdu_busy (CNT_W), stall_cycles. All clear on rst_n=0 at clk edge.
//  - Reset outputs: convert_to_nop=0, if_id_write=1, pc_write=1, stall_cycles=0.
//  - raw_hz = (rs_used & rs_addr!=0 & sb_cnt[rs]!=0) | (rt_used & rt_addr!=0 & sb_cnt[rt]!=0).
//  - struct_hz = id_is_mul & mdu_busy!=0.
//  - stall = id_valid & ~id_flush & (raw_hz | struct_hz). Combinational, same cycle as ID contents.
//  - Outputs: convert_to_nop=stall; if_id_write=~stall; pc_write=~stall.
//  - issue = id_valid & ~id_flush & ~stall. Flushed or stalled instructions never update state.
//  - Every edge: each nonzero sb_cnt and mdu_busy decrements by 1, saturating at 0.
//  - On issue with id_wr_en & wr_addr!=0, overwrite sb_cnt[wr_addr]:
//    LOAD_LAT if load, MUL_LAT if mul, else 0. Set wins over decrement; the set value is not decremented that edge.
//  - On issue with id_is_mul: mdu_busy <= MUL_LAT.
//  - WAW: the younger writer overwrites older count, even if smaller (forwarding picks the younger value).
//  - Sources are checked against pre-update counts, so an instruction never stalls on its own destination.
//  - Register 0 is never tracked; sb_cnt[0] stays 0.
//  - Timing: a load issued at edge t makes a dependent in ID at t+1 stall exactly LOAD_LAT cycles.
//  - id_flush does not clear counters of already-issued (older) instructions; this is conservative and correct.
//  - stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
//  - Reset asserted mid-stall: next cycle all counters are 0 and stall=0.
// STRUCTURE
//  - hazard_pkg: latency-class enum {LAT_ALU, LAT_LOAD, LAT_MUL}, and function lat_of(class) returning 0/LOAD_LAT/MUL_LAT.
//  - Sub-module hazard_cnt_cell: one countdown counter with load/decrement/saturate. Generated per register (1..NUM_REGS-1) and used once for mdu_busy.
//  - Top: hazard compare, issue logic, perf counter.
// TESTING
//  - Load-use: lw $5 issues, add rs=$5 next -> convert_to_nop=1 for 1 cycle, pc_write=0 that cycle, stall_cycles=1.
//  - Mul chain (MUL_LAT=4): mul $7, then dependent add -> 4 stall cycles. With a second mul, not dependent -> 4-cycle structural stall.
//  - $0 dest: lw $0, then add rs=$0 -> no stall.
//  - Flush: id_flush=1 with a hazard present -> stall=0 and no counter set; the next instruction's hazard is evaluated normally.
//  - WAW: lw $3 then addu $3 (rs=$9) issue; then a reader of $3 -> stall per overwritten count 0 -> no stall.
//  - Reset: rst_n=0 during a 3-cycle mul stall -> next cycle stall=0, stall_cycles=0, all counts 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: latency classes of a destination
// write and the mapping from class to forwarding latency.
package hazard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU,
    LAT_LOAD,
    LAT_MUL
  } lat_class_e;

  function automatic int lat_of(lat_class_e cls, int load_lat, int mul_lat);
    case (cls)
      LAT_LOAD: return load_lat;
      LAT_MUL:  return mul_lat;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_cnt_cell.sv
// One countdown counter: a set load wins over the decrement, and the
// count otherwise decrements toward zero and holds there.
module hazard_cnt_cell #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [CNT_W-1:0] set_val,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (set) begin
      cnt <= set_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and MDU busy tracker beside the ID stage; stalls PC and
// IF/ID and inserts an EX bubble while a source or the MDU is not yet ready.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MUL_LAT    = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_flush,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  id_is_mul,
  output logic                  convert_to_nop,
  output logic                  if_id_write,
  output logic                  pc_write,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int MAX_LAT  = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int CNT_W    = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] sb_cnt [NUM_REGS];
  logic [CNT_W-1:0] mdu_busy;
  logic [CNT_W-1:0] wr_set_val;
  lat_class_e       wr_class;
  logic             raw_hz;
  logic             struct_hz;
  logic             stall;
  logic             issue;

  // Hazards are judged on pre-update counts, so an instruction never waits on its own destination.
  always_comb begin
    raw_hz    = (id_rs_used && (id_rs_addr != '0) && (sb_cnt[id_rs_addr] != '0)) ||
                (id_rt_used && (id_rt_addr != '0) && (sb_cnt[id_rt_addr] != '0));
    struct_hz = id_is_mul && (mdu_busy != '0);
    stall     = id_valid && !id_flush && (raw_hz || struct_hz);
    issue     = id_valid && !id_flush && !stall;
  end

  always_comb begin
    if (id_is_load)     wr_class = LAT_LOAD;
    else if (id_is_mul) wr_class = LAT_MUL;
    else                wr_class = LAT_ALU;
    wr_set_val = CNT_W'(lat_of(wr_class, LOAD_LAT, MUL_LAT));
  end

  assign convert_to_nop = stall;
  assign if_id_write    = !stall;
  assign pc_write       = !stall;

  // $0 is hardwired, so it never gets a counter.
  assign sb_cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg_cnt
    hazard_cnt_cell #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .set    (issue && id_wr_en && (id_wr_addr == REG_ADDR_W'(r))),
      .set_val(wr_set_val),
      .cnt    (sb_cnt[r])
    );
  end

  hazard_cnt_cell #(
    .CNT_W(CNT_W)
  ) u_mdu_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (issue && id_is_mul),
    .set_val(CNT_W'(MUL_LAT)),
    .cnt    (mdu_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with a queue of expected outputs;
// a narrow perf counter makes the saturation reachable.
module tb_hazard_scoreboard;

  localparam int AW     = 5;
  localparam int LLAT   = 1;
  localparam int MLAT   = 4;
  localparam int PW     = 3;
  localparam int PERF_MAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_flush;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_wr_addr;
  logic          id_rs_used, id_rt_used, id_wr_en, id_is_load, id_is_mul;
  logic          convert_to_nop, if_id_write, pc_write;
  logic [PW-1:0] stall_cycles;

  hazard_scoreboard #(
    .REG_ADDR_W(AW),
    .LOAD_LAT  (LLAT),
    .MUL_LAT   (MLAT),
    .PERF_W    (PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_flush      (id_flush),
    .id_rs_addr    (id_rs_addr),
    .id_rs_used    (id_rs_used),
    .id_rt_addr    (id_rt_addr),
    .id_rt_used    (id_rt_used),
    .id_wr_addr    (id_wr_addr),
    .id_wr_en      (id_wr_en),
    .id_is_load    (id_is_load),
    .id_is_mul     (id_is_mul),
    .convert_to_nop(convert_to_nop),
    .if_id_write   (if_id_write),
    .pc_write      (pc_write),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          valid;
    logic          flush;
    logic [AW-1:0] rs;
    logic          rsu;
    logic [AW-1:0] rt;
    logic          rtu;
    logic [AW-1:0] wr;
    logic          wre;
    logic          ld;
    logic          mul;
    logic          exp_stall;
  } vec_t;

  typedef struct {
    logic          stall;
    logic [PW-1:0] perf;
    int            idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_perf = 0;

  function automatic vec_t mk(bit r, bit v, bit f, int rs, bit rsu, int rt, bit rtu,
                              int wr, bit wre, bit ld, bit mul, bit st);
    vec_t x;
    x.rst = r; x.valid = v; x.flush = f;
    x.rs = AW'(rs); x.rsu = rsu; x.rt = AW'(rt); x.rtu = rtu;
    x.wr = AW'(wr); x.wre = wre; x.ld = ld; x.mul = mul; x.exp_stall = st;
    return x;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n      = v.rst;
    id_valid   = v.valid;
    id_flush   = v.flush;
    id_rs_addr = v.rs;
    id_rs_used = v.rsu;
    id_rt_addr = v.rt;
    id_rt_used = v.rtu;
    id_wr_addr = v.wr;
    id_wr_en   = v.wre;
    id_is_load = v.ld;
    id_is_mul  = v.mul;
  endtask

  task automatic advance_model(bit rst, bit st);
    if (!rst) exp_perf = 0;
    else if (st && exp_perf != PERF_MAX) exp_perf++;
  endtask

  initial begin
    exp_t e;
    int   n_st;
    bit   done;

    // reset/idle, then the directed scenarios cycle by cycle
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0));
    // load-use
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 5,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 5,1, 6,1, 8,1,0,0, 1));
    vecs.push_back(mk(1,1,0, 5,1, 6,1, 8,1,0,0, 0));
    // mul then dependent add
    vecs.push_back(mk(1,1,0, 1,1, 2,1, 7,1,0,1, 0));
    for (int i = 0; i < MLAT; i++) vecs.push_back(mk(1,1,0, 7,1, 0,0, 9,1,0,0, 1));
    vecs.push_back(mk(1,1,0, 7,1, 0,0, 9,1,0,0, 0));
    // back-to-back independent muls (structural)
    vecs.push_back(mk(1,1,0, 1,1, 2,1, 10,1,0,1, 0));
    for (int i = 0; i < MLAT; i++) vecs.push_back(mk(1,1,0, 3,1, 4,1, 11,1,0,1, 1));
    vecs.push_back(mk(1,1,0, 3,1, 4,1, 11,1,0,1, 0));
    for (int i = 0; i < MLAT; i++) vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0));
    // $0 destination is never tracked
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 0,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 0,1, 0,1, 8,1,0,0, 0));
    // flush with hazard present: no stall and no counter set
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 12,1,1,0, 0));
    vecs.push_back(mk(1,1,1, 12,1, 0,0, 13,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 13,1, 0,0, 8,1,0,0, 0));
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 14,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 14,1, 0,0, 8,1,0,0, 1));
    vecs.push_back(mk(1,1,0, 14,1, 0,0, 8,1,0,0, 0));
    // WAW: younger ALU write to $3 clears the load count
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 3,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 9,1, 0,0, 3,1,0,0, 0));
    vecs.push_back(mk(1,1,0, 3,1, 0,0, 8,1,0,0, 0));
    // rt path, and rt ignored when unused
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 15,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 0,0, 15,1, 8,1,0,0, 1));
    vecs.push_back(mk(1,1,0, 0,0, 15,1, 8,1,0,0, 0));
    vecs.push_back(mk(1,1,0, 1,1, 0,0, 16,1,1,0, 0));
    vecs.push_back(mk(1,1,0, 0,0, 16,0, 8,1,0,0, 0));
    // reset during a mul stall
    vecs.push_back(mk(1,1,0, 1,1, 2,1, 17,1,0,1, 0));
    vecs.push_back(mk(1,1,0, 17,1, 0,0, 18,1,0,0, 1));
    vecs.push_back(mk(1,1,0, 17,1, 0,0, 18,1,0,0, 1));
    vecs.push_back(mk(0,1,0, 17,1, 0,0, 18,1,0,0, 1));
    vecs.push_back(mk(1,1,0, 17,1, 0,0, 18,1,0,0, 0));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0));

    drive(mk(0,0,0, 0,0, 0,0, 0,0,0,0, 0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      e.stall = vecs[i].exp_stall;
      e.perf  = PW'(exp_perf);
      e.idx   = i;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      check($sformatf("row%0d convert_to_nop", e.idx), int'(convert_to_nop), int'(e.stall));
      check($sformatf("row%0d if_id_write", e.idx), int'(if_id_write), int'(!e.stall));
      check($sformatf("row%0d pc_write", e.idx), int'(pc_write), int'(!e.stall));
      check($sformatf("row%0d stall_cycles", e.idx), int'(stall_cycles), int'(e.perf));
      advance_model(vecs[i].rst, vecs[i].exp_stall);
    end

    // mul latency measured by holding a dependent in ID until it issues
    @(posedge clk);
    #1;
    drive(mk(1,1,0, 1,1, 2,1, 20,1,0,1, 0));
    @(posedge clk);
    #1;
    drive(mk(1,1,0, 20,1, 0,0, 21,1,0,0, 0));
    n_st = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (convert_to_nop) begin
        n_st++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL mul_dep_timeout: stall still high after 20 cycles, expected release");
    end
    check("mul_dep_stall_len", n_st, MLAT);
    check("mul_dep_perf", int'(stall_cycles), MLAT);

    @(posedge clk);
    #1;
    drive(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0));
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
